// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/ack
// handshake, and holds the decoded opcode until the datapath accepts it.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W   = 12,
    parameter int unsigned        INSTR_W  = 19,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [5:0]         instruction,
    output logic [INSTR_W-1:0] instr_word,
    output logic               instr_valid,
    input  logic               instr_accept,
    input  logic               sel_PCSCrc_plus1,
    input  logic               sel_PCSCrc_const,
    input  logic               sel_ALUScr_offset,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [ADDR_W-1:0]  branch_offset,
    output logic [ADDR_W-1:0]  pc,
    output logic               illegal_op
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned OP_LO = INSTR_W - OP_W;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  next_pc_c;
    logic               illegal_c;

    // Next-PC selection; constant jump wins, then conditional offset, then plus-one.
    always_comb begin
        next_pc_c = pc + ADDR_W'(1);
        illegal_c = 1'b0;
        if (sel_PCSCrc_const) begin
            next_pc_c = jump_target;
        end else if (sel_ALUScr_offset) begin
            if (branch_taken) begin
                next_pc_c = pc + branch_offset;
            end
        end else if (!sel_PCSCrc_plus1) begin
            illegal_c = 1'b1;
        end
    end

    // Fetch/issue sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instruction <= '0;
            instr_word  <= '0;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                S_FETCH: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        instr_word  <= imem_rdata;
                        instruction <= imem_rdata[INSTR_W-1:OP_LO];
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Selects and branch operands only matter on the accept cycle.
                    if (instr_accept) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc_c;
                        illegal_op  <= illegal_c;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/branch/reset steps
// plus a randomized run, checked against a transaction-level PC model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INSTR_W = 19;
    localparam int          MEM_N   = 4096;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;
    logic [5:0]         instruction;
    logic [INSTR_W-1:0] instr_word;
    logic               instr_valid;
    logic               instr_accept;
    logic               sel_PCSCrc_plus1;
    logic               sel_PCSCrc_const;
    logic               sel_ALUScr_offset;
    logic               branch_taken;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  branch_offset;
    logic [ADDR_W-1:0]  pc;
    logic               illegal_op;

    int n_total = 0;
    int n_pass  = 0;
    int exp_pc  = 0;
    logic [INSTR_W-1:0] mem [MEM_N];

    instr_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_ack          (imem_ack),
        .instruction       (instruction),
        .instr_word        (instr_word),
        .instr_valid       (instr_valid),
        .instr_accept      (instr_accept),
        .sel_PCSCrc_plus1  (sel_PCSCrc_plus1),
        .sel_PCSCrc_const  (sel_PCSCrc_const),
        .sel_ALUScr_offset (sel_ALUScr_offset),
        .branch_taken      (branch_taken),
        .jump_target       (jump_target),
        .branch_offset     (branch_offset),
        .pc                (pc),
        .illegal_op        (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic mod 2^12.
    function automatic int model_next(input int cur, input bit c, input bit o, input bit t,
                                      input bit p, input int jt, input int off, output bit ill);
        ill = 1'b0;
        if (c) return jt;
        if (o && t) return (cur + off) % MEM_N;
        if (!o && !p) ill = 1'b1;
        return (cur + 1) % MEM_N;
    endfunction

    task automatic rand_side();
        sel_PCSCrc_plus1  = 1'($urandom_range(0, 1));
        sel_PCSCrc_const  = 1'($urandom_range(0, 1));
        sel_ALUScr_offset = 1'($urandom_range(0, 1));
        branch_taken      = 1'($urandom_range(0, 1));
        jump_target       = ADDR_W'($urandom);
        branch_offset     = ADDR_W'($urandom);
    endtask

    // One full fetch -> issue -> accept transaction.
    task automatic do_instr(input bit c, input bit o, input bit t, input bit p,
                            input int jt, input int off, input int lat, input int acc_dly);
        int n;
        bit ill;
        int nxt;
        logic [INSTR_W-1:0] w;
        n = 0;
        while (imem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
        chk("pc_fetch", 32'(pc), 32'(exp_pc));
        w = mem[exp_pc];
        for (int i = 0; i < lat; i++) begin
            rand_side();
            instr_accept = 1'($urandom_range(0, 1));
            imem_rdata   = INSTR_W'($urandom);
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'(exp_pc));
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        instr_accept = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = INSTR_W'($urandom);
        chk("valid_rise", 32'(instr_valid), 32'd1);
        chk("opcode", 32'(instruction), 32'(w[18:13]));
        chk("word", 32'(instr_word), 32'(w));
        chk("req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < acc_dly; i++) begin
            rand_side();
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_word", 32'(instr_word), 32'(w));
            chk("hold_opcode", 32'(instruction), 32'(w[18:13]));
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_pc", 32'(pc), 32'(exp_pc));
        end
        sel_PCSCrc_const  = c;
        sel_ALUScr_offset = o;
        branch_taken      = t;
        sel_PCSCrc_plus1  = p;
        jump_target       = ADDR_W'(jt);
        branch_offset     = ADDR_W'(off);
        instr_accept      = 1'b1;
        nxt = model_next(exp_pc, c, o, t, p, jt, off, ill);
        @(negedge clk);
        instr_accept = 1'b0;
        rand_side();
        chk("valid_clear", 32'(instr_valid), 32'd0);
        chk("next_pc", 32'(pc), 32'(nxt));
        chk("illegal", 32'(illegal_op), 32'(ill));
        exp_pc = nxt;
        @(negedge clk);
        chk("illegal_pulse_end", 32'(illegal_op), 32'd0);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", 32'(imem_addr), 32'(exp_pc));
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = INSTR_W'($urandom);
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        instr_accept = 1'b0;
        rand_side();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_opcode", 32'(instruction), 32'd0);
        chk("rst_word", 32'(instr_word), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 0;

        // Sequential plus-one fetches 0..4, then a constant jump from pc 5.
        for (int i = 0; i < 5; i++) do_instr(0, 0, 0, 1, 0, 0, 1, 0);
        do_instr(1, 0, 0, 0, 'h123, 0, 1, 0);
        chk("jump_0x123", 32'(imem_addr), 32'h123);
        // Conditional at 0x010 with offset -4, taken then not taken.
        do_instr(1, 0, 0, 0, 'h010, 0, 1, 0);
        do_instr(0, 1, 1, 0, 0, 'hFFC, 1, 0);
        chk("branch_taken_addr", 32'(imem_addr), 32'h00C);
        do_instr(1, 0, 0, 0, 'h010, 0, 1, 0);
        do_instr(0, 1, 0, 0, 0, 'hFFC, 1, 0);
        chk("branch_not_taken_addr", 32'(imem_addr), 32'h011);
        // Wrap from all-ones.
        do_instr(1, 0, 0, 0, 'hFFF, 0, 1, 0);
        do_instr(0, 0, 0, 1, 0, 0, 1, 0);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        // Slow memory and slow consumer.
        do_instr(0, 0, 0, 1, 0, 0, 5, 3);
        // No select: illegal pulse, pc+1.
        do_instr(0, 0, 0, 0, 'h555, 'h333, 1, 1);
        // Multiple selects resolved by priority.
        do_instr(1, 1, 1, 1, 'h0AB, 5, 2, 0);
        do_instr(0, 1, 1, 1, 'h321, 7, 1, 2);

        for (int k = 0; k < 30; k++) begin
            do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(0, MEM_N - 1)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for memory; a stale ack right after release is ignored.
        @(negedge clk);
        chk("pre_reset_wait", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_word", 32'(instr_word), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = INSTR_W'($urandom);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'd0);
        exp_pc = 0;
        do_instr(0, 0, 0, 1, 0, 0, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-issue core and the supply side of the instruction decode interface.
- Holds the program counter, fetches words from instruction memory over a req/ack handshake, and presents the 6-bit opcode field to the decode Controller.
- Consumes the Controller's PC-source selects (plus1 / const / conditional-offset) with the datapath's branch outcome to form the next PC.
- Each instruction moves through fetch, issue and redirect in sequence.

Parameters:
- ADDR_W, 12, width of PC and instruction memory address.
- INSTR_W, 19, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-6].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_rdata  in  INSTR_W  fetched word; valid when imem_ack=1.
- imem_ack  in  1  one-cycle completion pulse; ignored when imem_req=0.
- instruction  out  6  opcode field to Controller.
- instr_word  out  INSTR_W  full registered instruction to datapath.
- instr_valid  out  1  instruction/instr_word are valid.
- instr_accept  in  1  datapath consumes the current instruction this cycle.
- sel_PCSCrc_plus1  in  1  from Controller.
- sel_PCSCrc_const  in  1  from Controller (unconditional jump).
- sel_ALUScr_offset  in  1  from Controller (conditional jump).
- branch_taken  in  1  datapath condition result for a conditional jump.
- jump_target  in  ADDR_W  absolute target for unconditional jump.
- branch_offset  in  ADDR_W  two's-complement offset for conditional jump.
- pc  out  ADDR_W  address of the instruction in flight.
- illegal_op  out  1  one-cycle pulse: accepted instruction had no PC select asserted.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0, instruction=0, instr_word=0, illegal_op=0. Reset mid-fetch or mid-issue abandons the transaction; a pending imem_ack after reset is ignored.
- FSM states FETCH, WAIT, ISSUE; all outputs registered.
- FETCH: one cycle; drive imem_req=1, imem_addr=pc; go to WAIT.
- WAIT: keep imem_req=1 with stable address until imem_ack. On ack, latch imem_rdata into instr_word and its top 6 bits into instruction, set instr_valid=1, clear imem_req, go to ISSUE. No ack means stay, with no timeout.
- Minimum latency: imem_req rises 1 cycle after entering FETCH; instr_valid rises 1 cycle after imem_ack.
- ISSUE: instr_valid=1; instruction, instr_word and pc held stable until instr_accept=1.
- PC selects, branch_taken, jump_target and branch_offset are sampled only in the cycle instr_valid && instr_accept.
- On accept: instr_valid cleared next cycle, pc updated, state to FETCH.
- Next-PC priority:
  1. sel_PCSCrc_const=1: pc <= jump_target.
  2. sel_ALUScr_offset=1 and branch_taken=1: pc <= pc + branch_offset.
  3. sel_ALUScr_offset=1 and branch_taken=0: pc <= pc + 1.
  4. sel_PCSCrc_plus1=1: pc <= pc + 1.
  5. No select asserted: pc <= pc + 1, and illegal_op pulses high for exactly the following cycle.
- Several selects asserted at once: the priority above applies, with no error.
- Arithmetic is modulo 2^ADDR_W: pc=all-ones plus 1 gives 0, and negative offsets wrap the same way. No overflow flag.
- instr_accept while instr_valid=0 is ignored.
- Exactly one outstanding memory request; no prefetch or speculation.

Test Plan:
- Reset with RESET_PC=0, memory ack latency 1, three R-type words, instr_accept always 1 with plus1=1 -> imem_addr 0,1,2; each instr_valid 2 cycles after its req; opcodes match word bits [18:13].
- Word at pc=5 with sel_PCSCrc_const=1, jump_target=0x123 -> next imem_addr=0x123.
- Conditional at pc=0x010, offset=0xFFC (-4): branch_taken=1 -> next addr 0x00C; repeat with taken=0 -> 0x011.
- pc=0xFFF with plus1 -> next imem_addr=0x000 (wrap).
- Ack delayed 5 cycles and instr_accept held low 3 cycles -> imem_req/imem_addr stable throughout WAIT; instr_word stable while instr_valid=1; no second req issued.
- Accept with no select asserted -> illegal_op is a single-cycle pulse, pc advances by 1.
- rst_n asserted during WAIT, ack arrives 1 cycle after release -> ack ignored; fetch restarts at RESET_PC with outputs at reset values.
